// File: rtl/cash_dispenser_if.sv
// Withdrawal request, stock load/query and note-feed handshake between the
// ATM controller / note mechanism (master) and the cash dispenser (slave).
// Ports: request (entregar_dinero, monto), stock load (carga_*), stock query
// (consulta_tipo, existencia), note feed (billete_stb/tipo/ack), status
// (ocupado, entrega_completa, error_entrega, codigo_error).
interface cash_dispenser_if;
  logic        entregar_dinero;
  logic [31:0] monto;
  logic        carga_stb;
  logic [1:0]  carga_tipo;
  logic [15:0] carga_cantidad;
  logic [1:0]  consulta_tipo;
  logic [15:0] existencia;
  logic        billete_stb;
  logic [1:0]  billete_tipo;
  logic        billete_ack;
  logic        ocupado;
  logic        entrega_completa;
  logic        error_entrega;
  logic [1:0]  codigo_error;

  // Controller / mechanism side.
  modport master (
    output entregar_dinero, monto, carga_stb, carga_tipo, carga_cantidad,
           consulta_tipo, billete_ack,
    input  existencia, billete_stb, billete_tipo, ocupado, entrega_completa,
           error_entrega, codigo_error
  );

  // Dispenser side.
  modport slave (
    input  entregar_dinero, monto, carga_stb, carga_tipo, carga_cantidad,
           consulta_tipo, billete_ack,
    output existencia, billete_stb, billete_tipo, ocupado, entrega_completa,
           error_entrega, codigo_error
  );
endinterface

// File: rtl/cash_dispenser.sv
// Greedy banknote planner and one-note-at-a-time feeder for the ATM withdrawal path.
// Latency: request to first billete_stb is 2 + plan steps (notes planned + 4).
// Backpressure: each note waits in WAIT_ACK for billete_ack; requests while busy are dropped.
//
// Ports: clk, reset (synchronous, active low) and the slave side of
// cash_dispenser_if (request, stock load/query, note feed, status).
// Optional feature macro: CASH_DISPENSER_ACK_TIMEOUT_EN aborts a note with
// code 3 after ACK_TIMEOUT cycles without billete_ack.
module cash_dispenser #(
  parameter int unsigned DEN0        = 20000,
  parameter int unsigned DEN1        = 10000,
  parameter int unsigned DEN2        = 5000,
  parameter int unsigned DEN3        = 1000,
  parameter int unsigned MAX_BILLS   = 16,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input logic            clk,
  input logic            reset,
  cash_dispenser_if.slave bus
);

  // Plan and total counters only ever reach MAX_BILLS.
  localparam int TW = $clog2(MAX_BILLS + 1);
  typedef logic [TW-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    DISPENSE,
    WAIT_ACK,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_ZERO    = 2'd0;
  localparam logic [1:0] ERR_NOREP   = 2'd1;
  localparam logic [1:0] ERR_TOOMANY = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t      state, state_nx;
  logic [15:0] stock    [4];
  logic [15:0] stock_nx [4];
  cnt_t        plan     [4];
  cnt_t        plan_nx  [4];
  cnt_t        total, total_nx;
  logic [31:0] restante, restante_nx;
  logic [1:0]  idx, idx_nx;
  logic [1:0]  cur_d, cur_d_nx;
  logic [1:0]  codigo, codigo_nx;

  function automatic logic [31:0] den_of(input logic [1:0] i);
    logic [31:0] v;
    case (i)
      2'd0:    v = DEN0;
      2'd1:    v = DEN1;
      2'd2:    v = DEN2;
      default: v = DEN3;
    endcase
    return v;
  endfunction

  // Current greedy step: can one more note of denomination idx be taken?
  logic [31:0] den_cur;
  logic        can_take;
  assign den_cur  = den_of(idx);
  assign can_take = (restante >= den_cur) && (16'(plan[idx]) < stock[idx]);

  // Saturating stock load.
  logic [16:0] load_sum;
  assign load_sum = {1'b0, stock[bus.carga_tipo]} + {1'b0, bus.carga_cantidad};

  // Lowest denomination index still owed; the plan fills indices in
  // ascending order, so notes leave largest first.
  logic [1:0] pend_d;
  logic       pend_any;
  always_comb begin
    pend_d   = 2'd0;
    pend_any = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (plan[i] != '0) begin
        pend_d   = 2'(i);
        pend_any = 1'b1;
      end
    end
  end

`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
  localparam int OW = $clog2(ACK_TIMEOUT + 1);
  logic [OW-1:0] ack_cnt, ack_cnt_nx;
  logic          ack_expired;
  // ack_cnt counts completed WAIT_ACK cycles of the current note, so the
  // strobe is held for exactly ACK_TIMEOUT cycles before giving up.
  assign ack_expired = (ack_cnt == OW'(ACK_TIMEOUT - 1));
`else
  logic ack_expired;
  logic unused_ack_timeout;
  assign ack_expired        = 1'b0;
  assign unused_ack_timeout = (ACK_TIMEOUT != 0);
`endif

  // Next-state, datapath update and outputs.
  always_comb begin
    state_nx    = state;
    stock_nx    = stock;
    plan_nx     = plan;
    total_nx    = total;
    restante_nx = restante;
    idx_nx      = idx;
    cur_d_nx    = cur_d;
    codigo_nx   = codigo;
`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
    ack_cnt_nx  = ack_cnt;
`endif

    bus.existencia       = stock[bus.consulta_tipo];
    bus.ocupado          = (state != IDLE);
    bus.billete_stb      = (state == WAIT_ACK);
    bus.billete_tipo     = (state == WAIT_ACK) ? cur_d : 2'd0;
    bus.entrega_completa = (state == DONE);
    bus.error_entrega    = (state == ERROR);
    bus.codigo_error     = codigo;

    unique case (state)
      IDLE: begin
        if (bus.carga_stb) begin
          stock_nx[bus.carga_tipo] = load_sum[16] ? 16'hFFFF : load_sum[15:0];
        end
        if (bus.entregar_dinero) begin
          restante_nx = bus.monto;
          plan_nx     = '{default: '0};
          idx_nx      = 2'd0;
          total_nx    = '0;
          if (bus.monto == 32'd0) begin
            codigo_nx = ERR_ZERO;
            state_nx  = ERROR;
          end else begin
            state_nx = PLAN;
          end
        end
      end

      // One greedy step per cycle: take a note of idx, or move to idx+1.
      PLAN: begin
        if (can_take) begin
          if (total == cnt_t'(MAX_BILLS)) begin
            codigo_nx = ERR_TOOMANY;
            state_nx  = ERROR;
          end else begin
            plan_nx[idx] = plan[idx] + cnt_t'(1);
            total_nx     = total + cnt_t'(1);
            restante_nx  = restante - den_cur;
          end
        end else if (idx == 2'd3) begin
          if (restante == 32'd0) begin
            state_nx = DISPENSE;
          end else begin
            codigo_nx = ERR_NOREP;
            state_nx  = ERROR;
          end
        end else begin
          idx_nx = idx + 2'd1;
        end
      end

      DISPENSE: begin
        if (pend_any) begin
          cur_d_nx = pend_d;
          state_nx = WAIT_ACK;
`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
          ack_cnt_nx = '0;
`endif
        end else begin
          state_nx = DONE;
        end
      end

      // Stock is only debited once the mechanism has taken the note.
      WAIT_ACK: begin
        if (bus.billete_ack) begin
          plan_nx[cur_d]  = plan[cur_d] - cnt_t'(1);
          stock_nx[cur_d] = stock[cur_d] - 16'd1;
          state_nx        = DISPENSE;
        end else if (ack_expired) begin
          codigo_nx = ERR_TIMEOUT;
          state_nx  = ERROR;
        end else begin
`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
          ack_cnt_nx = ack_cnt + OW'(1);
`endif
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      // Whatever was still planned is dropped on any abort.
      ERROR: begin
        plan_nx  = '{default: '0};
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      total    <= '0;
      restante <= '0;
      idx      <= 2'd0;
      cur_d    <= 2'd0;
      codigo   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        stock[i] <= '0;
        plan[i]  <= '0;
      end
`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
      ack_cnt  <= '0;
`endif
    end else begin
      state    <= state_nx;
      stock    <= stock_nx;
      plan     <= plan_nx;
      total    <= total_nx;
      restante <= restante_nx;
      idx      <= idx_nx;
      cur_d    <= cur_d_nx;
      codigo   <= codigo_nx;
`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
      ack_cnt  <= ack_cnt_nx;
`endif
    end
  end

  a_total_cap: assert property (@(posedge clk) disable iff (!reset)
    total <= cnt_t'(MAX_BILLS));

endmodule

// File: tb/tb_cash_dispenser.sv
// Randomized scoreboard bench for cash_dispenser: expected note/completion/
// error events are queued when a request is issued and popped by a monitor.
module tb_cash_dispenser;
  localparam int MAXB = 16;
  localparam int EV_DONE = 4;
  localparam int EV_ERR  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cash_dispenser_if bus();

`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
  cash_dispenser #(.ACK_TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  cash_dispenser dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  int lat_q[$];
  int stock_m[4];
  int last_code = 0;
  int cyc = 0;
  int note_cnt = 0;
  int acks_given = 0;
  int ack_limit = 1 << 30;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int den(input int i);
    case (i)
      0:       return 20000;
      1:       return 10000;
      2:       return 5000;
      default: return 1000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin : monitor
    logic prev_stb;
    bit   first;
    int   e;
    prev_stb = 1'b0;
    first    = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.ocupado) first = 1'b1;
      if (bus.billete_stb && !prev_stb) begin
        note_cnt++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check("note_tipo", int'(bus.billete_tipo), e);
        if (first) begin
          first = 1'b0;
          check("first_note_latency", cyc, (lat_q.size() != 0) ? lat_q.pop_front() : -1);
        end
      end
      if (bus.entrega_completa) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check("completion_event", EV_DONE, e);
      end
      if (bus.error_entrega) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        check("error_event", EV_ERR + int'(bus.codigo_error), e);
      end
      prev_stb = bus.billete_stb;
    end
  end

  // Mechanism model: accepts each note after 0..2 cycles while acks are allowed.
  initial begin : ack_driver
    int d;
    bus.billete_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.billete_stb && acks_given < ack_limit) begin
        d = $urandom_range(0, 2);
        repeat (d) @(negedge clk);
        bus.billete_ack = 1'b1;
        acks_given++;
        @(negedge clk);
        bus.billete_ack = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.ocupado && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (bus.ocupado) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic check_stock(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.consulta_tipo = 2'(i);
      #1;
      check({tag, "_stock"}, int'(bus.existencia), stock_m[i]);
    end
    @(negedge clk);
  endtask

  task automatic expect_stock(input string tag, input int a, input int b, input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      bus.consulta_tipo = 2'(i);
      #1;
      check({tag, "_const_stock"}, int'(bus.existencia), v[i]);
    end
    @(negedge clk);
  endtask

  task automatic load(input int t, input int q);
    bus.carga_stb      = 1'b1;
    bus.carga_tipo     = 2'(t);
    bus.carga_cantidad = 16'(q);
    @(negedge clk);
    bus.carga_stb = 1'b0;
    stock_m[t] = (stock_m[t] + q > 65535) ? 65535 : stock_m[t] + q;
  endtask

  // Reference model: greedy take per denomination, then cap and remainder tests.
  task automatic issue(input int m);
    int rem, tot, n, code;
    int take[4];
    rem  = m;
    tot  = 0;
    code = -1;
    if (m == 0) code = 0;
    else begin
      for (int d = 0; d < 4; d++) begin
        n = rem / den(d);
        if (n > stock_m[d]) n = stock_m[d];
        take[d] = n;
        rem -= n * den(d);
        tot += n;
      end
      if (tot > MAXB) code = 2;
      else if (rem != 0) code = 1;
    end
    if (code < 0) begin
      lat_q.push_back(cyc + 6 + tot);
      for (int d = 0; d < 4; d++) begin
        for (int k = 0; k < take[d]; k++) exp_q.push_back(d);
        stock_m[d] -= take[d];
      end
      exp_q.push_back(EV_DONE);
    end else begin
      exp_q.push_back(EV_ERR + code);
      last_code = code;
    end
    bus.monto = 32'(m);
    bus.entregar_dinero = 1'b1;
    @(negedge clk);
    bus.entregar_dinero = 1'b0;
  endtask

  task automatic request(input int m, input bit poke);
    wait_idle();
    issue(m);
    if (poke && bus.ocupado) begin
      bus.monto = 32'(m + 1000);
      bus.entregar_dinero = 1'b1;
      @(negedge clk);
      bus.entregar_dinero = 1'b0;
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("codigo_hold", int'(bus.codigo_error), last_code);
    check_stock("post_txn");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    check("rst_billete_stb", int'(bus.billete_stb), 0);
    check("rst_billete_tipo", int'(bus.billete_tipo), 0);
    check("rst_entrega_completa", int'(bus.entrega_completa), 0);
    check("rst_error_entrega", int'(bus.error_entrega), 0);
    check("rst_ocupado", int'(bus.ocupado), 0);
    check("rst_codigo_error", int'(bus.codigo_error), 0);
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    for (int i = 0; i < 4; i++) stock_m[i] = 0;
    last_code = 0;
    check_stock("after_reset");
  endtask

  initial begin : main
    int base, t, m;
    bus.entregar_dinero = 1'b0;
    bus.monto           = '0;
    bus.carga_stb       = 1'b0;
    bus.carga_tipo      = 2'd0;
    bus.carga_cantidad  = '0;
    bus.consulta_tipo   = 2'd0;
    reset               = 1'b0;
    do_reset();

    // Directed: full greedy mix, then a non-representable amount.
    for (int i = 0; i < 4; i++) load(i, 10);
    request(36000, 1'b0);
    expect_stock("m36000", 9, 9, 9, 9);
    request(36500, 1'b0);
    expect_stock("m36500", 9, 9, 9, 9);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        t = $urandom_range(0, 3);
        load(t, ($urandom_range(0, 5) == 0) ? 16'hFFF0 : $urandom_range(0, 15));
      end
      case ($urandom_range(0, 9))
        0:       m = 0;
        1:       m = 1000 * $urandom_range(1, 40) + 500;
        2:       m = 1000 * $urandom_range(100, 400);
        default: m = 1000 * $urandom_range(1, 80);
      endcase
      request(m, $urandom_range(0, 3) == 0);
    end

    // Reset while the second note is waiting for its ack.
    wait_idle();
    for (int i = 0; i < 4; i++) load(i, 10);
    base = note_cnt;
    ack_limit = acks_given + 1;
    issue(36000);
    t = 0;
    while (note_cnt < base + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("second_note_reached", note_cnt - base, 2);
    repeat (2) @(negedge clk);
    do_reset();
    ack_limit = 1 << 30;
    request(1000, 1'b0);

    // Only denomination 1 stocked.
    load(1, 10);
    request(40000, 1'b0);
    expect_stock("m40000", 0, 6, 0, 0);

    // Small notes only: note cap, then zero amount.
    do_reset();
    load(3, 30);
    request(17000, 1'b0);
    request(0, 1'b1);
    expect_stock("cap", 0, 0, 0, 30);

    // Saturating stock load.
    load(2, 65000);
    load(2, 1000);
    expect_stock("sat", 0, 0, 65535, 30);

`ifdef CASH_DISPENSER_ACK_TIMEOUT_EN
    // Withheld ack: strobe held for 8 cycles then code 3; second request ignored.
    wait_idle();
    ack_limit = acks_given;
    lat_q.push_back(cyc + 7);
    exp_q.push_back(3);
    exp_q.push_back(EV_ERR + 3);
    bus.monto = 32'd1000;
    bus.entregar_dinero = 1'b1;
    @(negedge clk);
    bus.entregar_dinero = 1'b0;
    @(negedge clk);
    bus.monto = 32'd20000;
    bus.entregar_dinero = 1'b1;
    @(negedge clk);
    bus.entregar_dinero = 1'b0;
    t = 0;
    base = 0;
    while (bus.ocupado && t < 200) begin
      if (bus.billete_stb) base++;
      @(negedge clk);
      t++;
    end
    check("timeout_stb_cycles", base, 8);
    last_code = 3;
    ack_limit = 1 << 30;
    repeat (2) @(negedge clk);
    check("timeout_drained", exp_q.size(), 0);
    check("timeout_code_hold", int'(bus.codigo_error), 3);
    check_stock("timeout");
`endif

    repeat (5) @(negedge clk);
    check("final_scoreboard_empty", exp_q.size() + lat_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
